// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (write port, read/line-fill port) onto one native memory port.
// Grants whole bursts; the decision is registered, so each grant is preceded by an idle cycle.
//   state    | meaning
//   IDLE     | no grant; picks the next requester
//   GNT_WR   | write port owns the memory port for 2^WR_BURST_W beats
//   GNT_RD   | read port owns the memory port for 2^RD_BURST_W beats
module mem_port_arbiter #(
    parameter int BE_ADDR_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int WR_BURST_W = 0,
    parameter int RD_BURST_W = 3,
    parameter int PRIO       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [BE_ADDR_W-1:0]     wr_addr,
    input  logic [BE_DATA_W-1:0]     wr_wdata,
    input  logic [BE_DATA_W/8-1:0]   wr_wstrb,
    output logic                     wr_ready,
    input  logic                     rd_valid,
    input  logic [BE_ADDR_W-1:0]     rd_addr,
    output logic [BE_DATA_W-1:0]     rd_rdata,
    output logic                     rd_ready,
    output logic                     mem_valid,
    output logic [BE_ADDR_W-1:0]     mem_addr,
    output logic [BE_DATA_W-1:0]     mem_wdata,
    output logic [BE_DATA_W/8-1:0]   mem_wstrb,
    input  logic [BE_DATA_W-1:0]     mem_rdata,
    input  logic                     mem_ready,
    output logic [1:0]               gnt,
    output logic                     busy
);
    localparam int BE_NBYTES = BE_DATA_W / 8;
    localparam int MAX_BW    = (WR_BURST_W > RD_BURST_W) ? WR_BURST_W : RD_BURST_W;
    localparam int CNT_W     = (MAX_BW > 1) ? MAX_BW : 1;

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((1 << WR_BURST_W) - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((1 << RD_BURST_W) - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT_WR = 2'd1;
    localparam logic [1:0] S_GNT_RD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_rd_q, last_rd_d;

    assign rd_rdata = mem_rdata;
    assign busy     = (gnt != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = {BE_NBYTES{1'b0}};
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        gnt       = 2'b00;

        case (state_q)
            S_IDLE: begin
                // last_rd_q set means the read port had the previous grant, so write is owed next
                if (wr_valid && (!rd_valid || (PRIO == 0) || last_rd_q)) begin
                    state_d   = S_GNT_WR;
                    cnt_d     = '0;
                    last_rd_d = 1'b0;
                end else if (rd_valid) begin
                    state_d   = S_GNT_RD;
                    cnt_d     = '0;
                    last_rd_d = 1'b1;
                end
            end
            S_GNT_WR: begin
                gnt       = 2'b01;
                mem_valid = wr_valid;
                mem_addr  = wr_addr;
                mem_wdata = wr_wdata;
                mem_wstrb = wr_wstrb;
                wr_ready  = mem_ready;
                if (mem_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == WR_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GNT_RD: begin
                gnt       = 2'b10;
                mem_valid = rd_valid;
                mem_addr  = rd_addr;
                rd_ready  = mem_ready;
                if (mem_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == RD_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 is write-through/fixed priority,
// instance 1 is 4-beat write-back/round-robin; both use 8-beat line fills.
module tb_mem_port_arbiter;

    localparam logic [31:0] RD_KEY = 32'h5EED_0000;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid [2];
    logic [31:0] wr_addr  [2];
    logic [31:0] wr_wdata [2];
    logic [3:0]  wr_wstrb [2];
    logic        wr_ready [2];
    logic        rd_valid [2];
    logic [31:0] rd_addr  [2];
    logic [31:0] rd_rdata [2];
    logic        rd_ready [2];
    logic        mem_valid[2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [3:0]  mem_wstrb[2];
    logic [31:0] mem_rdata[2];
    logic        mem_ready[2];
    logic [1:0]  gnt      [2];
    logic        busy     [2];

    int n_checks = 0;
    int n_pass   = 0;

    beat_t wr_q[$];
    beat_t rd_q[$];
    logic [1:0] glog0[$];
    logic [1:0] glog1[$];

    // monitor-owned counters
    int wr_seen[2] = '{0, 0};
    int rd_seen[2] = '{0, 0};
    int wr_cyc [2] = '{0, 0};
    int rd_cyc [2] = '{0, 0};
    int bubble_err = 0;
    logic [1:0] prev_gnt[2] = '{2'b00, 2'b00};

    // requester-owned state
    int          wr_done[2], rd_done[2], wr_left[2], rd_left[2], wr_beat[2], rd_beat[2];
    logic [31:0] wr_base[2], rd_base[2];
    logic        rand_ready[2];

    always #5 clk = ~clk;

    assign mem_rdata[0] = mem_addr[0] ^ RD_KEY;
    assign mem_rdata[1] = mem_addr[1] ^ RD_KEY;

    mem_port_arbiter #(.BE_ADDR_W(32), .BE_DATA_W(32), .WR_BURST_W(0), .RD_BURST_W(3), .PRIO(0)) u_arb0 (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]), .wr_wdata(wr_wdata[0]), .wr_wstrb(wr_wstrb[0]),
        .wr_ready(wr_ready[0]),
        .rd_valid(rd_valid[0]), .rd_addr(rd_addr[0]), .rd_rdata(rd_rdata[0]), .rd_ready(rd_ready[0]),
        .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
        .gnt(gnt[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.BE_ADDR_W(32), .BE_DATA_W(32), .WR_BURST_W(2), .RD_BURST_W(3), .PRIO(1)) u_arb1 (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]), .wr_wdata(wr_wdata[1]), .wr_wstrb(wr_wstrb[1]),
        .wr_ready(wr_ready[1]),
        .rd_valid(rd_valid[1]), .rd_addr(rd_addr[1]), .rd_rdata(rd_rdata[1]), .rd_ready(rd_ready[1]),
        .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
        .gnt(gnt[1]), .busy(busy[1])
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] wdata_f(input logic [31:0] base, input int beat);
        return base ^ 32'hDA7A_0000 ^ 32'(beat);
    endfunction

    function automatic logic [3:0] strb_f(input int beat);
        logic [3:0] full;
        full = 4'hF;
        return full >> (beat % 4);
    endfunction

    // per-cycle protocol checks and scoreboard pops
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check_val("busy", 64'(busy[i]), 64'(gnt[i] != 2'b00));
            check_val("rd_rdata_pass", 64'(rd_rdata[i]), 64'(mem_addr[i] ^ RD_KEY));
            if (gnt[i] == 2'b00) begin
                check_val("idle_outs", 64'({mem_valid[i], mem_wstrb[i], wr_ready[i], rd_ready[i]}), 64'(0));
            end else if (gnt[i] == 2'b01) begin
                wr_cyc[i]++;
                check_val("wr_ctl", 64'({mem_valid[i], mem_wstrb[i], wr_ready[i], rd_ready[i]}),
                          64'({wr_valid[i], wr_wstrb[i], mem_ready[i], 1'b0}));
                check_val("wr_path", {mem_addr[i], mem_wdata[i]}, {wr_addr[i], wr_wdata[i]});
            end else if (gnt[i] == 2'b10) begin
                rd_cyc[i]++;
                check_val("rd_ctl", 64'({mem_valid[i], mem_wstrb[i], wr_ready[i], rd_ready[i]}),
                          64'({rd_valid[i], 4'h0, 1'b0, mem_ready[i]}));
                check_val("rd_path", {mem_addr[i], mem_wdata[i]}, {rd_addr[i], 32'h0});
            end else begin
                check_val("gnt_onehot", 64'(gnt[i]), 64'(0));
            end
            if (gnt[i] != 2'b00 && gnt[i] != prev_gnt[i]) begin
                if (prev_gnt[i] != 2'b00) bubble_err++;
                if (i == 0) glog0.push_back(gnt[i]);
                else        glog1.push_back(gnt[i]);
            end
            prev_gnt[i] = gnt[i];
            if (wr_ready[i]) begin
                wr_seen[i]++;
                if (wr_q.size() == 0) check_val("wr_unexpected", 64'(1), 64'(0));
                else begin
                    beat_t e;
                    e = wr_q.pop_front();
                    check_val("wr_inst", 64'(i), 64'(e.inst));
                    check_val("wr_beat", {mem_addr[i], mem_wdata[i]}, {e.addr, e.data});
                    check_val("wr_strb", 64'(mem_wstrb[i]), 64'(e.strb));
                end
            end
            if (rd_ready[i]) begin
                rd_seen[i]++;
                if (rd_q.size() == 0) check_val("rd_unexpected", 64'(1), 64'(0));
                else begin
                    beat_t e;
                    e = rd_q.pop_front();
                    check_val("rd_inst", 64'(i), 64'(e.inst));
                    check_val("rd_beat", {mem_addr[i], rd_rdata[i]}, {e.addr, e.data});
                end
            end
        end
    end

    task automatic drive_req(input int i);
        wr_valid[i] = (wr_left[i] > 0);
        wr_addr[i]  = wr_base[i] + 32'(4 * wr_beat[i]);
        wr_wdata[i] = wdata_f(wr_base[i], wr_beat[i]);
        wr_wstrb[i] = strb_f(wr_beat[i]);
        rd_valid[i] = (rd_left[i] > 0);
        rd_addr[i]  = rd_base[i] + 32'(4 * rd_beat[i]);
    endtask

    task automatic start_wr(input int i, input logic [31:0] base, input int n);
        wr_base[i] = base; wr_beat[i] = 0; wr_left[i] = n;
        for (int k = 0; k < n; k++)
            wr_q.push_back('{inst: i, addr: base + 32'(4 * k), data: wdata_f(base, k), strb: strb_f(k)});
        drive_req(i);
    endtask

    task automatic start_rd(input int i, input logic [31:0] base, input int n);
        rd_base[i] = base; rd_beat[i] = 0; rd_left[i] = n;
        for (int k = 0; k < n; k++)
            rd_q.push_back('{inst: i, addr: base + 32'(4 * k), data: (base + 32'(4 * k)) ^ RD_KEY, strb: 4'h0});
        drive_req(i);
    endtask

    // advance one clock; requesters move on after each accepted beat
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (wr_seen[i] != wr_done[i]) begin
                wr_done[i]++;
                if (wr_left[i] > 0) begin wr_left[i]--; wr_beat[i]++; end
            end
            if (rd_seen[i] != rd_done[i]) begin
                rd_done[i]++;
                if (rd_left[i] > 0) begin rd_left[i]--; rd_beat[i]++; end
            end
            drive_req(i);
            if (rand_ready[i]) mem_ready[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic abort_all();
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < 2; i++) begin
            wr_done[i] = wr_seen[i]; rd_done[i] = rd_seen[i];
            wr_left[i] = 0; rd_left[i] = 0;
            drive_req(i);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((wr_left[0] + wr_left[1] + rd_left[0] + rd_left[1]) != 0 && k < budget) begin
            tick();
            k++;
        end
        check_val("drain_done", 64'(wr_left[0] + wr_left[1] + rd_left[0] + rd_left[1]), 64'(0));
        check_val("sb_empty", 64'(wr_q.size() + rd_q.size()), 64'(0));
        repeat (2) tick();
    endtask

    function automatic int log_size(input int i);
        return (i == 0) ? glog0.size() : glog1.size();
    endfunction

    task automatic check_order(input string tag, input int i, input int start, input int n, input logic [7:0] exp);
        logic [7:0] got;
        int sz;
        got = '0;
        sz = log_size(i);
        check_val({tag, "_count"}, 64'(sz - start), 64'(n));
        for (int k = 0; k < 4; k++)
            if (k < n && start + k < sz)
                got[2*k +: 2] = (i == 0) ? glog0[start + k] : glog1[start + k];
        check_val(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s_log, s_wc, s_rc, s_ws, s_rs, s_bub, p_rd;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_done[i] = 0; rd_done[i] = 0; wr_left[i] = 0; rd_left[i] = 0;
            wr_beat[i] = 0; rd_beat[i] = 0; wr_base[i] = '0; rd_base[i] = '0;
            rand_ready[i] = 1'b0; mem_ready[i] = 1'b0;
            drive_req(i);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val("rst_gnt", 64'(gnt[i]), 64'(0));
            check_val("rst_outs", 64'({busy[i], mem_valid[i], mem_wstrb[i], wr_ready[i], rd_ready[i]}), 64'(0));
        end

        // single write-through beat, memory answers on the second granted cycle
        tick();
        s_wc = wr_cyc[0]; s_ws = wr_seen[0];
        start_wr(0, 32'h100, 1);
        @(negedge clk); check_val("wr1_c0_gnt", 64'(gnt[0]), 64'(2'b00));
        tick();
        @(negedge clk); check_val("wr1_c1", 64'({gnt[0], mem_valid[0], wr_ready[0]}), 64'({2'b01, 1'b1, 1'b0}));
        tick(); mem_ready[0] = 1'b1;
        @(negedge clk); check_val("wr1_c2", 64'({gnt[0], mem_valid[0], wr_ready[0]}), 64'({2'b01, 1'b1, 1'b1}));
        tick(); mem_ready[0] = 1'b0;
        @(negedge clk); check_val("wr1_c3_idle", 64'(gnt[0]), 64'(2'b00));
        check_val("wr1_pulses", 64'(wr_seen[0] - s_ws), 64'(1));
        check_val("wr1_valid_cycles", 64'(wr_cyc[0] - s_wc), 64'(2));

        // 8-beat line fill with memory always ready
        tick();
        s_rc = rd_cyc[0]; s_rs = rd_seen[0]; s_log = log_size(0);
        start_rd(0, 32'h200, 8); mem_ready[0] = 1'b1;
        drain(40);
        check_val("fill_pulses", 64'(rd_seen[0] - s_rs), 64'(8));
        check_val("fill_gnt_cycles", 64'(rd_cyc[0] - s_rc), 64'(8));
        check_order("fill_order", 0, s_log, 1, 8'h02);

        // simultaneous requests, fixed priority: write, bubble, read
        s_log = log_size(0); s_bub = bubble_err;
        start_wr(0, 32'h300, 1); start_rd(0, 32'h400, 8);
        drain(40);
        check_order("prio0_order", 0, s_log, 2, 8'h09);
        check_val("prio0_bubble", 64'(bubble_err - s_bub), 64'(0));

        // round-robin with both held for two grants each
        s_log = log_size(1); s_wc = wr_cyc[1]; s_rc = rd_cyc[1];
        mem_ready[1] = 1'b1;
        start_wr(1, 32'h500, 8); start_rd(1, 32'h600, 16);
        drain(80);
        check_order("rr_order", 1, s_log, 4, 8'h99);
        check_val("rr_wr_cycles", 64'(wr_cyc[1] - s_wc), 64'(8));
        check_val("rr_rd_cycles", 64'(rd_cyc[1] - s_rc), 64'(16));

        // read request arriving at beat 1 of a write-back burst waits for the burst
        s_log = log_size(1); s_bub = bubble_err;
        start_wr(1, 32'h700, 4);
        tick(); tick();
        start_rd(1, 32'h800, 8);
        drain(40);
        check_order("wb_order", 1, s_log, 2, 8'h09);
        check_val("wb_bubble", 64'(bubble_err - s_bub), 64'(0));

        // random memory stalls; fixed priority lets repeated writes go first
        s_log = log_size(0);
        rand_ready[0] = 1'b1;
        start_wr(0, 32'h900, 3); start_rd(0, 32'hA00, 8);
        drain(300);
        rand_ready[0] = 1'b0;
        check_order("stall_order", 0, s_log, 4, 8'h95);

        // reset during beat 4 of a line fill
        mem_ready[0] = 1'b1;
        start_rd(0, 32'hB00, 8);
        p_rd = rd_done[0];
        for (int k = 0; k < 20 && (rd_done[0] - p_rd) < 3; k++) tick();
        check_val("abort_beats", 64'(rd_done[0] - p_rd), 64'(3));
        reset = 1'b1; mem_ready[0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        abort_all();
        s_log = log_size(0);
        mem_ready[0] = 1'b1;
        start_rd(0, 32'hC00, 8); start_wr(0, 32'hD00, 1);
        @(negedge clk);
        check_val("abort_idle", 64'({gnt[0], mem_valid[0], rd_ready[0]}), 64'(0));
        drain(40);
        check_order("abort_order", 0, s_log, 2, 8'h09);

        // reset must restore write preference under round-robin
        start_wr(1, 32'hE00, 4);
        drain(20);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        s_log = log_size(1);
        start_wr(1, 32'hF00, 4); start_rd(1, 32'h1000, 8);
        drain(40);
        check_order("rst_pref_order", 1, s_log, 2, 8'h09);

        // memory ready while idle is ignored
        s_ws = wr_seen[0] + wr_seen[1]; s_rs = rd_seen[0] + rd_seen[1];
        mem_ready[0] = 1'b1; mem_ready[1] = 1'b1;
        repeat (4) tick();
        check_val("idle_ready_pulses", 64'((wr_seen[0] + wr_seen[1] - s_ws) + (rd_seen[0] + rd_seen[1] - s_rs)), 64'(0));
        s_wc = wr_cyc[1];
        start_wr(1, 32'h1100, 4);
        drain(20);
        check_val("post_idle_burst", 64'(wr_cyc[1] - s_wc), 64'(4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter BE_ADDR_W, default 32: back-end byte-address width.
REQ-002 SHALL have parameter BE_DATA_W, default 32: back-end data width (BE_NBYTES = BE_DATA_W/8).
REQ-003 SHALL have parameter WR_BURST_W, default 0: log2 of beats per write grant (0 = write-through, single beat).
REQ-004 SHALL have parameter RD_BURST_W, default 3: log2 of beats per read (line-fill) grant.
REQ-005 SHALL have parameter PRIO, default 0: 0 = fixed write priority, 1 = round-robin.
REQ-006 SHALL have ports clk in 1 (system clock) and reset in 1; one clock, reset synchronous and active-high.
REQ-007 SHALL have write-requester ports wr_valid in 1, wr_addr in BE_ADDR_W, wr_wdata in BE_DATA_W, wr_wstrb in BE_NBYTES, wr_ready out 1.
REQ-008 SHALL have read-requester ports rd_valid in 1, rd_addr in BE_ADDR_W, rd_rdata out BE_DATA_W, rd_ready out 1.
REQ-009 SHALL have native memory ports mem_valid out 1, mem_addr out BE_ADDR_W, mem_wdata out BE_DATA_W, mem_wstrb out BE_NBYTES, mem_rdata in BE_DATA_W, mem_ready in 1.
REQ-010 SHALL have status outputs gnt out 2 ({rd,wr} one-hot or zero) and busy out 1 (gnt != 0).

Function
REQ-011 SHALL implement state machine IDLE, GNT_WR, GNT_RD held in a register, plus beat counter of max(WR_BURST_W,RD_BURST_W,1) bits.
REQ-012 In IDLE: mem_valid=0, mem_wstrb=0, wr_ready=0, rd_ready=0, gnt=0.
REQ-013 IDLE -> GNT_WR when wr_valid and (not rd_valid or PRIO=0 or last grant was read); IDLE -> GNT_RD when rd_valid otherwise; else stay IDLE.
REQ-014 Arbitration decision SHALL be registered: first beat presented to memory one cycle after the request is sampled in IDLE.
REQ-015 In GNT_WR: mem_valid=wr_valid, mem_addr=wr_addr, mem_wdata=wr_wdata, mem_wstrb=wr_wstrb, wr_ready=mem_ready, rd_ready=0.
REQ-016 In GNT_RD: mem_valid=rd_valid, mem_addr=rd_addr, mem_wdata=0, mem_wstrb=0, rd_ready=mem_ready, wr_ready=0.
REQ-017 rd_rdata SHALL equal mem_rdata combinationally in every state.
REQ-018 Beat counter SHALL clear on grant entry and increment on each cycle with mem_ready=1 while granted.
REQ-019 Grant SHALL end (-> IDLE) on the cycle mem_ready=1 with counter = 2^BURST_W-1 for the granted requester; no interleaving within a burst.
REQ-020 Beats SHALL be counted on mem_ready only; a requester deasserting valid in the same cycle as mem_ready (valid = ~mem_ready style) SHALL NOT lose or repeat a beat.
REQ-021 mem_ready while in IDLE SHALL be ignored (no counter change, no ready to requesters).
REQ-022 Round-robin last-grant register SHALL update on each grant entry; after reset it SHALL favour write.
REQ-023 Under PRIO=0 a continuous write stream MAY starve reads; under PRIO=1 simultaneous requests SHALL alternate grants.
REQ-024 Returning to IDLE costs one bubble cycle between consecutive grants.

Reset
REQ-025 On a clock edge with reset=1: state=IDLE, counter=0, last-grant=read (so write favoured next); all outputs take REQ-012 values the following cycle.
REQ-026 Reset mid-burst SHALL abandon the burst without completing remaining beats; no ready is issued after the reset edge.

Verification
REQ-027 Single write, WR_BURST_W=0: wr_valid=1, addr 0x100, wstrb 0xF, mem_ready after 2 cycles -> gnt=01 one cycle after request, mem_valid high 2 cycles, wr_ready pulses once, state IDLE next cycle.
REQ-028 Line fill, RD_BURST_W=3: rd_valid=1, mem_ready every cycle -> exactly 8 rd_ready pulses, rd_rdata follows mem_rdata, gnt=10 for 8 cycles then 00.
REQ-029 Simultaneous wr_valid/rd_valid, PRIO=0 -> write granted first, read granted after one bubble; PRIO=1 with both held -> grant order wr, rd, wr, rd.
REQ-030 Write-back burst WR_BURST_W=2 with rd_valid asserted at beat 1 -> all 4 write beats complete before gnt=10; mem_wstrb=0 throughout read grant.
REQ-031 reset=1 at beat 3 of an 8-beat read -> next cycle gnt=00, mem_valid=0, rd_ready=0; a new write request is then granted first.
REQ-032 mem_ready=1 pulsed in IDLE with no requests -> no ready pulses, counter and state unchanged.
